control_datapath: RTL and testbench
===================================

// Module: control_datapath
// PURPOSE
// - Single-cycle 24-bit CPU core: opcode decoder (control unit), PC, 16x24 register file, ALU, 256x24 data memory.
// - Drives the fetch address to the external instruction memory and executes the returned 24-bit word combinationally.
// - Commits all state on one clock edge.
// PARAMETERS
// - RESET_PC  24'd10  PC value while reset_n is low
// - DMEM_AW   8       data-memory address bits (256 words)
// PORTS
// - Clocking: one clock; reset is asynchronous and active-low.
// - clock         in   1   rising-edge clock
// - reset_n       in   1   async active-low reset
// - instruction   in   24  instruction word at pc
// - pc            out  24  current program counter (fetch address)
// - reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  out 1 each  decoded controls
// - alu_op        out  2   00 add, 01 sub, 10 funct, 11 imm-logic
// - alu_result    out  24  ALU output
// - zero          out  1   alu_result == 0
// - dbg_sel       in   4   register-file debug read select
// - dbg_data      out  24  register[dbg_sel], combinational
// BEHAVIOUR
// - Fields: op=[23:20], rs=[19:16], rt=[15:12], rd=[11:8], funct=[3:0], imm=[11:0].
// - Destination: rd when reg_dst=1, else rt.
// - Immediates: sign-extended, except ANDI/ORI, which zero-extend.
// - Opcodes:
//   - 0 R-type: dst=rd=rs OP rt; funct 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed); other funct -> result 0.
//   - 1 ADDI, 2 ANDI, 3 ORI, 8 SLTI (signed): rt = rs OP imm.
//   - 4 LW: rt = mem[(rs+sext)[7:0]]. 5 SW: mem[(rs+sext)[7:0]] = rt.
//   - 6 BEQ: taken when rs==rt (ALU sub, zero=1).
//   - 7, 9-F: NOP, all controls 0.
// - Control truth (dst,src,m2r,rw,mr,mw,br,aluop):
//   - R: 1,0,0,1,0,0,0,10
//   - ADDI: 0,1,0,1,0,0,0,00
//   - ANDI/ORI/SLTI: 0,1,0,1,0,0,0,11
//   - LW: 0,1,1,1,1,0,0,00
//   - SW: 0,1,0,0,0,1,0,00
//   - BEQ: 0,0,0,0,0,0,1,01
// - Single cycle: decode, regfile read, ALU and memory read are combinational from instruction.
// - Regfile write, memory write and PC update occur on the rising edge of clock.
// - Next PC:
//   - pc+3 normally.
//   - pc + 3 + 3*sext(imm) on BEQ taken.
//   - All PC arithmetic mod 2^24.
// - Register r0 reads 0 always; writes to r0 are discarded.
// - Arithmetic is 24-bit two's complement; overflow wraps silently (no flag).
// - Regfile read-during-write returns the old value; the new value is visible next cycle.
// - Reset, including mid-operation: pc=RESET_PC and all 16 registers=0, immediately and asynchronously.
// - During reset: no memory write, pc frozen.
// - First rising edge after release executes the instruction at RESET_PC.
// - Data memory is not reset; its contents are undefined until written.
// - Outputs with reset_n low: controls still decode instruction combinationally; state is frozen.
// TESTING
// - Reset: run, drop reset_n between edges -> pc=10 and dbg r1..r15=0 at once; release, one edge -> pc=13.
// - Arith: 0x101005 -> r1=5; 0x102FFD -> r2=0xFFFFFD; 0x012300 (ADD) -> r3=2; 0x012401 (SUB) -> r4=8.
// - Memory: 0x501004 (SW r1 to mem[4], mem_write=1 that cycle only) then 0x405004 (LW r5) -> r5=5, mem_to_reg=1.
// - Branch at pc=P:
//   - 0x611002 -> branch=1, zero=1, next pc=P+9.
//   - 0x612002 -> next pc=P+3.
//   - imm 0xFFF -> next pc=P.
// - Edge:
//   - ADDI r0,0x100007 -> dbg r0=0.
//   - opcode 0xF -> all controls 0, pc+3.
//   - 0x7FFFFF+1 -> 0x800000.
//   - SLT(-1,1)=1.

Source files
------------

// File: rtl/control_datapath.sv
// Single-cycle 24-bit CPU core: decoder, PC, 16x24 register file, ALU and 256x24 data memory.
// All fetch-to-writeback logic is combinational from instruction; every state element commits on one rising edge.
`timescale 1ns/100ps

module control_datapath #(
    parameter logic [23:0] RESET_PC = 24'd10,
    parameter int          DMEM_AW  = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] instruction,
    output logic [23:0] pc,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic [1:0]  alu_op,
    output logic [23:0] alu_result,
    output logic        zero,
    input  logic [3:0]  dbg_sel,
    output logic [23:0] dbg_data
);

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_ANDI  = 4'h2;
    localparam logic [3:0] OP_ORI   = 4'h3;
    localparam logic [3:0] OP_LW    = 4'h4;
    localparam logic [3:0] OP_SW    = 4'h5;
    localparam logic [3:0] OP_BEQ   = 4'h6;
    localparam logic [3:0] OP_SLTI  = 4'h8;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } alu_op_e;

    logic [3:0]  op, rs, rt, rd, funct;
    logic [11:0] imm;
    logic [23:0] imm_sext, imm_ext;
    logic [23:0] rs_data, rt_data, operand_b;
    logic [23:0] mem_rdata, write_data;
    logic [3:0]  dst;
    logic [DMEM_AW-1:0] mem_addr;
    logic [23:0] pc_plus3, branch_off, pc_next;
    alu_op_e     alu_sel;

    logic [23:0] regs [16];
    logic [23:0] dmem [2**DMEM_AW];

    assign op    = instruction[23:20];
    assign rs    = instruction[19:16];
    assign rt    = instruction[15:12];
    assign rd    = instruction[11:8];
    assign funct = instruction[3:0];
    assign imm   = instruction[11:0];

    // Logic immediates zero-extend so ANDI/ORI can build unsigned bit masks.
    assign imm_sext = {{12{imm[11]}}, imm};
    assign imm_ext  = (op == OP_ANDI || op == OP_ORI) ? {12'b0, imm} : imm_sext;

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_sel    = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_sel   = ALU_FUNCT;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_SLTI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_sel   = ALU_IMM;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch  = 1'b1;
                alu_sel = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign alu_op = alu_sel;

    assign rs_data   = (rs == 4'd0) ? '0 : regs[rs];
    assign rt_data   = (rt == 4'd0) ? '0 : regs[rt];
    assign dbg_data  = (dbg_sel == 4'd0) ? '0 : regs[dbg_sel];
    assign operand_b = alu_src ? imm_ext : rt_data;

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            ALU_ADD: alu_result = rs_data + operand_b;
            ALU_SUB: alu_result = rs_data - operand_b;
            ALU_FUNCT: begin
                case (funct)
                    4'd0:    alu_result = rs_data + operand_b;
                    4'd1:    alu_result = rs_data - operand_b;
                    4'd2:    alu_result = rs_data & operand_b;
                    4'd3:    alu_result = rs_data | operand_b;
                    4'd4:    alu_result = rs_data ^ operand_b;
                    4'd5:    alu_result = {23'b0, $signed(rs_data) < $signed(operand_b)};
                    default: alu_result = '0;
                endcase
            end
            ALU_IMM: begin
                case (op)
                    OP_ANDI: alu_result = rs_data & operand_b;
                    OP_ORI:  alu_result = rs_data | operand_b;
                    OP_SLTI: alu_result = {23'b0, $signed(rs_data) < $signed(operand_b)};
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == 24'd0);

    assign mem_addr   = alu_result[DMEM_AW-1:0];
    assign mem_rdata  = dmem[mem_addr];
    assign write_data = mem_to_reg ? mem_rdata : alu_result;
    assign dst        = reg_dst ? rd : rt;

    // Branch displacement counts 3-byte instruction words: pc + 3 + 3*sext(imm), wrapping mod 2^24.
    assign pc_plus3   = pc + 24'd3;
    assign branch_off = {imm_sext[22:0], 1'b0} + imm_sext;
    assign pc_next    = (branch && zero) ? pc_plus3 + branch_off : pc_plus3;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (reg_write && dst != 4'd0) begin
            regs[dst] <= write_data;
        end
    end

    // NOTE: data memory is deliberately not reset (RAM-friendly); reset_n only gates its write enable.
    always_ff @(posedge clock) begin
        if (reset_n && mem_write) begin
            dmem[mem_addr] <= rt_data;
        end
    end

endmodule

// File: tb/tb_control_datapath.sv
// Self-checking bench for control_datapath: directed scenarios plus random instructions
// compared against an instruction-level reference model of the architectural state.
`timescale 1ns/100ps

module tb_control_datapath;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] instruction = 24'hF00000;
    logic [3:0]  dbg_sel = 4'd0;
    logic [23:0] pc, alu_result, dbg_data;
    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, zero;
    logic [1:0]  alu_op;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: architectural state only.
    logic [23:0] m_regs [16];
    logic [23:0] m_mem  [256];
    bit          m_valid [256];
    logic [23:0] m_pc;

    control_datapath dut (
        .clock(clock), .reset_n(reset_n), .instruction(instruction), .pc(pc),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .alu_op(alu_op),
        .alu_result(alu_result), .zero(zero), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] sx(input logic [11:0] i);
        return {{12{i[11]}}, i};
    endfunction

    // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
    function automatic logic [8:0] exp_ctrl(input logic [3:0] op);
        case (op)
            4'h0:             return 9'b1_0_0_1_0_0_0_10;
            4'h1:             return 9'b0_1_0_1_0_0_0_00;
            4'h2, 4'h3, 4'h8: return 9'b0_1_0_1_0_0_0_11;
            4'h4:             return 9'b0_1_1_1_1_0_0_00;
            4'h5:             return 9'b0_1_0_0_0_1_0_00;
            4'h6:             return 9'b0_0_0_0_0_0_1_01;
            default:          return 9'b0;
        endcase
    endfunction

    function automatic logic [23:0] exp_alu(input logic [23:0] ins);
        logic [23:0] a, b, s, z;
        a = m_regs[ins[19:16]];
        b = m_regs[ins[15:12]];
        s = sx(ins[11:0]);
        z = {12'b0, ins[11:0]};
        case (ins[23:20])
            4'h0: case (ins[3:0])
                      4'd0: return a + b;
                      4'd1: return a - b;
                      4'd2: return a & b;
                      4'd3: return a | b;
                      4'd4: return a ^ b;
                      4'd5: return ($signed(a) < $signed(b)) ? 24'd1 : 24'd0;
                      default: return 24'd0;
                  endcase
            4'h1, 4'h4, 4'h5: return a + s;
            4'h2: return a & z;
            4'h3: return a | z;
            4'h8: return ($signed(a) < $signed(s)) ? 24'd1 : 24'd0;
            4'h6: return a - b;
            default: return a + b;
        endcase
    endfunction

    function automatic bit is_nop(input logic [3:0] op);
        return (op == 4'h7) || (op >= 4'h9);
    endfunction

    task automatic model_step(input logic [23:0] ins);
        logic [23:0] r;
        r = exp_alu(ins);
        case (ins[23:20])
            4'h0:                   m_regs[ins[11:8]]  = r;
            4'h1, 4'h2, 4'h3, 4'h8: m_regs[ins[15:12]] = r;
            4'h4:                   m_regs[ins[15:12]] = m_mem[r[7:0]];
            4'h5: begin
                m_mem[r[7:0]]   = m_regs[ins[15:12]];
                m_valid[r[7:0]] = 1'b1;
            end
            default: ;
        endcase
        if (ins[23:20] == 4'h6 && r == 24'd0) m_pc = m_pc + 24'd3 + 24'd3 * sx(ins[11:0]);
        else                                  m_pc = m_pc + 24'd3;
        m_regs[0] = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_pc = 24'd10;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input logic [3:0] idx, output logic [23:0] val);
        dbg_sel = idx;
        #0.2;
        val = dbg_data;
    endtask

    task automatic test_reset();
        logic [23:0] v;
        reset_n = 1'b0;
        instruction = 24'hF00000;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (pc !== 24'd10) begin
            tests_failed++; $display("FAIL reset_pc: got %h want %h", pc, 24'd10);
        end
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), v);
            tests_run++;
            if (v !== 24'd0) begin
                tests_failed++; $display("FAIL reset_reg r%0d: got %h want 0", i, v);
            end
        end
        reset_n = 1'b1;
        model_reset();
        model_step(instruction);
        tick();
        tests_run++;
        if (pc !== 24'd13) begin
            tests_failed++; $display("FAIL release_pc: got %h want %h", pc, 24'd13);
        end
    endtask

    typedef struct { logic [23:0] ins; logic [3:0] r; logic [23:0] val; } vec_t;

    task automatic test_arith();
        vec_t t [4];
        logic [23:0] v;
        t[0] = '{24'h101005, 4'd1, 24'h000005};
        t[1] = '{24'h102FFD, 4'd2, 24'hFFFFFD};
        t[2] = '{24'h012300, 4'd3, 24'h000002};
        t[3] = '{24'h012401, 4'd4, 24'h000008};
        for (int i = 0; i < 4; i++) begin
            instruction = t[i].ins;
            #1;
            tests_run++;
            if (alu_result !== t[i].val || reg_write !== 1'b1) begin
                tests_failed++;
                $display("FAIL arith_alu %h: got %h rw=%b want %h rw=1", t[i].ins, alu_result, reg_write, t[i].val);
            end
            model_step(instruction);
            tick();
            peek(t[i].r, v);
            tests_run++;
            if (v !== t[i].val || pc !== m_pc) begin
                tests_failed++;
                $display("FAIL arith_wb r%0d: got %h pc %h want %h pc %h", t[i].r, v, pc, t[i].val, m_pc);
            end
        end
    endtask

    task automatic test_memory();
        logic [23:0] v;
        instruction = 24'h501004;
        #1;
        tests_run++;
        if (mem_write !== 1'b1 || reg_write !== 1'b0 || alu_result !== 24'd4) begin
            tests_failed++;
            $display("FAIL sw_ctrl: got mw=%b rw=%b addr=%h want mw=1 rw=0 addr=4", mem_write, reg_write, alu_result);
        end
        model_step(instruction);
        tick();
        instruction = 24'h405004;
        #1;
        tests_run++;
        if (mem_write !== 1'b0 || mem_to_reg !== 1'b1 || mem_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL lw_ctrl: got mw=%b m2r=%b mr=%b want 0 1 1", mem_write, mem_to_reg, mem_read);
        end
        model_step(instruction);
        tick();
        peek(4'd5, v);
        tests_run++;
        if (v !== 24'd5) begin
            tests_failed++; $display("FAIL lw_data r5: got %h want 5", v);
        end
    endtask

    task automatic test_branch();
        logic [23:0] p;
        p = m_pc;
        instruction = 24'h611002;
        #1;
        tests_run++;
        if (branch !== 1'b1 || zero !== 1'b1) begin
            tests_failed++; $display("FAIL beq_taken_ctrl: got br=%b z=%b want 1 1", branch, zero);
        end
        model_step(instruction);
        tick();
        tests_run++;
        if (pc !== p + 24'd9) begin
            tests_failed++; $display("FAIL beq_taken_pc: got %h want %h", pc, p + 24'd9);
        end
        p = m_pc;
        instruction = 24'h612002;
        #1;
        tests_run++;
        if (zero !== 1'b0) begin
            tests_failed++; $display("FAIL beq_not_taken_zero: got %b want 0", zero);
        end
        model_step(instruction);
        tick();
        tests_run++;
        if (pc !== p + 24'd3) begin
            tests_failed++; $display("FAIL beq_not_taken_pc: got %h want %h", pc, p + 24'd3);
        end
        p = m_pc;
        instruction = 24'h611FFF;
        model_step(instruction);
        tick();
        tests_run++;
        if (pc !== p) begin
            tests_failed++; $display("FAIL beq_self_pc: got %h want %h", pc, p);
        end
    endtask

    task automatic test_edge();
        logic [23:0] v, p;
        logic [8:0]  c;
        instruction = 24'h100007;
        model_step(instruction);
        tick();
        peek(4'd0, v);
        tests_run++;
        if (v !== 24'd0) begin
            tests_failed++; $display("FAIL r0_write: got %h want 0", v);
        end
        p = m_pc;
        instruction = 24'hF12345;
        #1;
        c = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
        tests_run++;
        if (c !== 9'b0) begin
            tests_failed++; $display("FAIL nop_ctrl: got %b want 000000000", c);
        end
        model_step(instruction);
        tick();
        tests_run++;
        if (pc !== p + 24'd3) begin
            tests_failed++; $display("FAIL nop_pc: got %h want %h", pc, p + 24'd3);
        end
        // Build 0x7FFFFF in r6 by doubling 1 up to 0x800000 and subtracting 1.
        instruction = 24'h106001; model_step(instruction); tick();
        for (int i = 0; i < 23; i++) begin
            instruction = 24'h066600; model_step(instruction); tick();
        end
        instruction = 24'h166FFF; model_step(instruction); tick();
        instruction = 24'h167001;
        #1;
        tests_run++;
        if (alu_result !== 24'h800000) begin
            tests_failed++; $display("FAIL wrap_add: got %h want 800000", alu_result);
        end
        model_step(instruction);
        tick();
        instruction = 24'h108FFF; model_step(instruction); tick();
        instruction = 24'h109001; model_step(instruction); tick();
        instruction = 24'h089A05; model_step(instruction); tick();
        peek(4'd10, v);
        tests_run++;
        if (v !== 24'd1) begin
            tests_failed++; $display("FAIL slt_signed: got %h want 1", v);
        end
    endtask

    task automatic test_random();
        logic [23:0] ins, r, v;
        logic [8:0]  c;
        logic [3:0]  sel, dst;
        for (int n = 0; n < 400; n++) begin
            ins = 24'($urandom);
            if (ins[23:20] == 4'h4) begin
                r = m_regs[ins[19:16]] + sx(ins[11:0]);
                if (!m_valid[r[7:0]]) ins[23:20] = 4'h5;
            end
            dst = (ins[23:20] == 4'h0) ? ins[11:8] : ins[15:12];
            sel = $urandom_range(0, 1) ? dst : 4'($urandom_range(0, 15));
            instruction = ins;
            dbg_sel = sel;
            #1;
            c = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
            r = exp_alu(ins);
            tests_run++;
            if (c !== exp_ctrl(ins[23:20])) begin
                tests_failed++; $display("FAIL rand_ctrl %h: got %b want %b", ins, c, exp_ctrl(ins[23:20]));
            end
            if (!is_nop(ins[23:20])) begin
                tests_run++;
                if (alu_result !== r || zero !== (r == 24'd0)) begin
                    tests_failed++;
                    $display("FAIL rand_alu %h: got %h z=%b want %h z=%b", ins, alu_result, zero, r, r == 24'd0);
                end
            end
            tests_run++;
            if (dbg_data !== m_regs[sel]) begin
                tests_failed++; $display("FAIL rand_dbg r%0d: got %h want %h", sel, dbg_data, m_regs[sel]);
            end
            model_step(ins);
            tick();
            tests_run++;
            if (pc !== m_pc) begin
                tests_failed++; $display("FAIL rand_pc after %h: got %h want %h", ins, pc, m_pc);
            end
        end
        for (int i = 0; i < 16; i++) begin
            peek(4'(i), v);
            tests_run++;
            if (v !== m_regs[i]) begin
                tests_failed++; $display("FAIL rand_final r%0d: got %h want %h", i, v, m_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] v;
        instruction = 24'h101123; model_step(instruction); tick();
        instruction = 24'h501009; model_step(instruction); tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (pc !== 24'd10) begin
            tests_failed++; $display("FAIL midreset_pc: got %h want %h", pc, 24'd10);
        end
        for (int i = 1; i < 16; i++) begin
            peek(4'(i), v);
            tests_run++;
            if (v !== 24'd0) begin
                tests_failed++; $display("FAIL midreset_reg r%0d: got %h want 0", i, v);
            end
        end
        instruction = 24'h500009;
        #1;
        tests_run++;
        if (mem_write !== 1'b1) begin
            tests_failed++; $display("FAIL reset_decode: got mw=%b want 1", mem_write);
        end
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (pc !== 24'd10) begin
            tests_failed++; $display("FAIL reset_frozen_pc: got %h want %h", pc, 24'd10);
        end
        reset_n = 1'b1;
        instruction = 24'h402009;
        model_step(instruction);
        tick();
        peek(4'd2, v);
        tests_run++;
        if (v !== 24'h000123 || pc !== 24'd13) begin
            tests_failed++;
            $display("FAIL reset_no_memwrite: got r2=%h pc=%h want r2=000123 pc=00000d", v, pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        model_reset();
        test_reset();
        test_arith();
        test_memory();
        test_branch();
        test_edge();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
